// File: rtl/div_root_pkg.sv
// Shared types and constants for the divide / n-th root engine.
// DIV_ROOT_ROUND_EN adds a guard quotient bit so divide results round half up.
package div_root_pkg;

   localparam int IN1_W  = 10;
   localparam int IN2_W  = 3;
   localparam int OUT_W  = 20;
   localparam int FRAC_W = 10;

`ifdef DIV_ROOT_ROUND_EN
   localparam int DIV_W = OUT_W + 1;
`else
   localparam int DIV_W = OUT_W;
`endif

   localparam logic MODE_DIV  = 1'b0;
   localparam logic MODE_ROOT = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      DIV,
      ROOT_MUL,
      ROOT_CMP,
      DONE
   } state_t;

endpackage

// File: rtl/fx_mul.sv
// Combinational 10.10 x 10.10 multiply returning a 10.10 product.
// sat flags any integer bits beyond the 10.10 range.
module fx_mul
   import div_root_pkg::*;
(
   input  logic [OUT_W-1:0] a,
   input  logic [OUT_W-1:0] b,
   output logic [OUT_W-1:0] p,
   output logic             sat
);

   logic [2*OUT_W-1:0] full;

   assign full = {{OUT_W{1'b0}}, a} * {{OUT_W{1'b0}}, b};
   assign p    = full[OUT_W+FRAC_W-1:FRAC_W];
   assign sat  = |full[2*OUT_W-1:OUT_W+FRAC_W];

endmodule

// File: rtl/div_root_engine.sv
// Iterative engine: restoring divide of x by k, or bitwise n-th root of x (10.10 result).
// Build option DIV_ROOT_ROUND_EN: divide rounds half up using one extra quotient bit.
module div_root_engine
   import div_root_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_mode,
   input  logic [IN1_W-1:0] in_data_1,
   input  logic [IN2_W-1:0] in_data_2,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data
);

   localparam int CNT_W = 5;

   state_t           state_reg, state_next;
   logic [OUT_W-1:0] tgt_reg, tgt_next;
   logic [IN2_W-1:0] k_reg, k_next;
   logic             mode_reg, mode_next;
   logic             zero_reg, zero_next;
   logic [DIV_W-1:0] acc_reg, acc_next;
   logic [DIV_W-1:0] dvd_reg, dvd_next;
   logic [IN2_W-1:0] rem_reg, rem_next;
   logic [CNT_W-1:0] bit_reg, bit_next;
   logic [IN2_W-1:0] mul_cnt_reg, mul_cnt_next;
   logic [OUT_W-1:0] p_reg, p_next;
   logic             sat_reg, sat_next;

   logic [OUT_W-1:0] trial, mul_a, mul_p, p_cmp;
   logic             mul_sat;
   logic [IN2_W:0]   rem_sh, rem_diff;
   logic [OUT_W-1:0] div_res, result;

   assign trial  = acc_reg[OUT_W-1:0] | ({{(OUT_W-1){1'b0}}, 1'b1} << bit_reg);
   assign mul_a  = (mul_cnt_reg == '0) ? trial : p_reg;
   assign p_cmp  = (k_reg == IN2_W'(1)) ? trial : p_reg;
   assign rem_sh   = {rem_reg, dvd_reg[DIV_W-1]};
   assign rem_diff = rem_sh - {1'b0, k_reg};

   fx_mul u_mul (
      .a   (mul_a),
      .b   (trial),
      .p   (mul_p),
      .sat (mul_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         tgt_reg     <= '0;
         k_reg       <= '0;
         mode_reg    <= 1'b0;
         zero_reg    <= 1'b0;
         acc_reg     <= '0;
         dvd_reg     <= '0;
         rem_reg     <= '0;
         bit_reg     <= '0;
         mul_cnt_reg <= '0;
         p_reg       <= '0;
         sat_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tgt_reg     <= tgt_next;
         k_reg       <= k_next;
         mode_reg    <= mode_next;
         zero_reg    <= zero_next;
         acc_reg     <= acc_next;
         dvd_reg     <= dvd_next;
         rem_reg     <= rem_next;
         bit_reg     <= bit_next;
         mul_cnt_reg <= mul_cnt_next;
         p_reg       <= p_next;
         sat_reg     <= sat_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      tgt_next     = tgt_reg;
      k_next       = k_reg;
      mode_next    = mode_reg;
      zero_next    = zero_reg;
      acc_next     = acc_reg;
      dvd_next     = dvd_reg;
      rem_next     = rem_reg;
      bit_next     = bit_reg;
      mul_cnt_next = mul_cnt_reg;
      p_next       = p_reg;
      sat_next     = sat_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               tgt_next     = {in_data_1, {FRAC_W{1'b0}}};
               dvd_next     = {in_data_1, {(DIV_W-IN1_W){1'b0}}};
               k_next       = in_data_2;
               mode_next    = in_mode;
               zero_next    = (in_mode == MODE_ROOT) && (in_data_2 == '0 || in_data_1 == '0);
               acc_next     = '0;
               rem_next     = '0;
               mul_cnt_next = '0;
               p_next       = '0;
               sat_next     = 1'b0;
               bit_next     = CNT_W'(OUT_W - 1);
               // Root with k = 0 borrows the divide sequencer purely for its timing
               if (in_mode == MODE_DIV) begin
                  bit_next   = CNT_W'(DIV_W - 1);
                  state_next = DIV;
               end else if (in_data_2 == '0) begin
                  state_next = DIV;
               end else if (in_data_2 == IN2_W'(1)) begin
                  state_next = ROOT_CMP;
               end else begin
                  state_next = ROOT_MUL;
               end
            end
         end
         DIV: begin
            dvd_next = dvd_reg << 1;
            if (rem_sh >= {1'b0, k_reg}) begin
               rem_next = rem_diff[IN2_W-1:0];
               acc_next = {acc_reg[DIV_W-2:0], 1'b1};
            end else begin
               rem_next = rem_sh[IN2_W-1:0];
               acc_next = {acc_reg[DIV_W-2:0], 1'b0};
            end
            bit_next = bit_reg - CNT_W'(1);
            if (bit_reg == '0) state_next = DONE;
         end
         ROOT_MUL: begin
            p_next       = mul_p;
            sat_next     = sat_reg | mul_sat;
            mul_cnt_next = mul_cnt_reg + IN2_W'(1);
            if (mul_cnt_reg == k_reg - IN2_W'(2)) state_next = ROOT_CMP;
         end
         ROOT_CMP: begin
            if (!sat_reg && p_cmp <= tgt_reg) acc_next = DIV_W'(trial);
            sat_next     = 1'b0;
            mul_cnt_next = '0;
            bit_next     = bit_reg - CNT_W'(1);
            if (bit_reg == '0)            state_next = DONE;
            else if (k_reg == IN2_W'(1)) state_next = ROOT_CMP;
            else                         state_next = ROOT_MUL;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef DIV_ROOT_ROUND_EN
   logic [DIV_W:0] rnd_sum;
   assign rnd_sum = {1'b0, acc_reg} + (DIV_W + 1)'(1);
   assign div_res = rnd_sum[DIV_W] ? {OUT_W{1'b1}} : rnd_sum[OUT_W:1];
`else
   assign div_res = acc_reg[OUT_W-1:0];
`endif

   assign result    = zero_reg ? '0 : ((mode_reg == MODE_DIV) ? div_res : acc_reg[OUT_W-1:0]);
   assign out_valid = (state_reg == DONE);
   assign out_data  = out_valid ? result : '0;

endmodule

// File: tb/tb_div_root_engine.sv
// Self-checking bench for div_root_engine: scoreboard of expected results and due cycles.
module tb_div_root_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_mode;
   logic [9:0]  in_data_1;
   logic [2:0]  in_data_2;
   logic        out_valid;
   logic [19:0] out_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [19:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

`ifdef DIV_ROOT_ROUND_EN
   localparam int DIV_LAT = 22;
`else
   localparam int DIV_LAT = 21;
`endif

   div_root_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_mode   (in_mode),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // out_data must be zero whenever no result is being presented
   always @(negedge clk) begin
      if (out_valid !== 1'b1) begin
         checks++;
         if (out_data !== 20'h0) begin
            errors++;
            $display("FAIL idle_zero got %h expected 00000 at cycle %0d", out_data, cyc);
         end
      end
   end

   function automatic logic [19:0] div_model(int x, int k);
      int q;
      if (k == 0) return 20'hFFFFF;
`ifdef DIV_ROOT_ROUND_EN
      q = (x * 2048) / k;
      q = (q + 1) / 2;
      if (q > 20'hFFFFF) q = 20'hFFFFF;
`else
      q = (x * 1024) / k;
`endif
      return q[19:0];
   endfunction

   // trial^k with each product truncated to 10.10; saturation returns a value above any target
   function automatic longint pow_trunc(longint v, int k);
      longint p = v;
      longint full;
      for (int i = 1; i < k; i++) begin
         full = p * v;
         if (full >= (longint'(1) << 30)) return longint'(1) << 40;
         p = full >> 10;
      end
      return p;
   endfunction

   function automatic logic [19:0] root_model(int x, int k);
      logic [19:0] r = 20'h0;
      logic [19:0] t;
      if (k == 0 || x == 0) return 20'h0;
      for (int b = 19; b >= 0; b--) begin
         t = r | (20'd1 << b);
         if (pow_trunc(longint'(t), k) <= longint'(x) * 1024) r = t;
      end
      return r;
   endfunction

   function automatic int lat_model(logic mode, int k);
      if (mode == 1'b0) return DIV_LAT;
      if (k == 0) return 21;
      return 20 * k + 1;
   endfunction

   task automatic issue(input logic mode, input int x, input int k, input logic [19:0] exp_data, input bit push);
      exp_t e;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_mode   = mode;
      in_data_1 = x[9:0];
      in_data_2 = k[2:0];
      if (push) begin
         e.data = exp_data;
         e.due  = cyc + lat_model(mode, k);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int seen, output logic [19:0] d, output bit to);
      to = 1'b1;
      seen = -1;
      d = 20'h0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid === 1'b1) begin
            to = 1'b0;
            seen = cyc;
            d = out_data;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_mode = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 20'h0) begin
         errors++;
         $display("FAIL reset_out got valid=%b data=%h expected valid=0 data=00000", out_valid, out_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_divide();
      int tx[8];
      int tk[8];
      logic [19:0] te[8];
      int seen;
      logic [19:0] d;
      bit to;
      exp_t e;
      tx = '{7, 1023, 2, 0, 1023, 5, 0, 0};
      tk = '{2, 7, 3, 5, 1, 0, 0, 0};
      te = '{20'h00E00, 20'h24892, 20'h002AA, 20'h00000, 20'hFFC00, 20'hFFFFF, 20'h0, 20'h0};
`ifdef DIV_ROOT_ROUND_EN
      te[2] = 20'h002AB;
`endif
      for (int i = 6; i < 8; i++) begin
         tx[i] = $urandom_range(1, 1023);
         tk[i] = $urandom_range(1, 7);
         te[i] = div_model(tx[i], tk[i]);
      end
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, tx[i], tk[i], te[i], 1'b1);
         wait_out(seen, d, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL div_timeout %0d/%0d got no out_valid expected result", tx[i], tk[i]);
            if (sb.size() > 0) void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (d !== e.data) begin
               errors++;
               $display("FAIL div_data %0d/%0d got %h expected %h", tx[i], tk[i], d, e.data);
            end
            checks++;
            if (seen != e.due) begin
               errors++;
               $display("FAIL div_latency %0d/%0d got cycle %0d expected %0d", tx[i], tk[i], seen, e.due);
            end
            $display("div %0d/%0d -> %h at cycle %0d", tx[i], tk[i], d, seen);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL div_pulse_width got %b expected 0", out_valid);
         end
      end
   endtask

   task automatic test_root();
      int tx[8];
      int tk[8];
      logic [19:0] te[8];
      int seen;
      logic [19:0] d;
      bit to;
      exp_t e;
      tx = '{100, 8, 1023, 0, 50, 1023, 0, 0};
      tk = '{2, 3, 1, 3, 0, 7, 0, 0};
      te = '{20'h02800, 20'h00800, 20'hFFC00, 20'h00000, 20'h00000, 20'h0, 20'h0, 20'h0};
      te[5] = root_model(1023, 7);
      for (int i = 6; i < 8; i++) begin
         tx[i] = $urandom_range(1, 1023);
         tk[i] = $urandom_range(1, 3);
         te[i] = root_model(tx[i], tk[i]);
      end
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, tx[i], tk[i], te[i], 1'b1);
         wait_out(seen, d, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL root_timeout x=%0d k=%0d got no out_valid expected result", tx[i], tk[i]);
            if (sb.size() > 0) void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (d !== e.data) begin
               errors++;
               $display("FAIL root_data x=%0d k=%0d got %h expected %h", tx[i], tk[i], d, e.data);
            end
            checks++;
            if (seen != e.due) begin
               errors++;
               $display("FAIL root_latency x=%0d k=%0d got cycle %0d expected %0d", tx[i], tk[i], seen, e.due);
            end
            if (tk[i] == 7) begin
               checks++;
               if (!(pow_trunc(longint'(d), 7) <= 1023 * 1024 && pow_trunc(longint'(d) + 1, 7) > 1023 * 1024)) begin
                  errors++;
                  $display("FAIL root7_bound got %h expected r^7<=1023<(r+lsb)^7", d);
               end
            end
            $display("root x=%0d k=%0d -> %h at cycle %0d", tx[i], tk[i], d, seen);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL root_pulse_width got %b expected 0", out_valid);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int seen;
      logic [19:0] d;
      bit to;
      bit extra = 1'b0;
      exp_t e;
      issue(1'b0, 7, 2, 20'h00E00, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b1; in_mode = 1'b1; in_data_1 = 10'd100; in_data_2 = 3'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(seen, d, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL busy_timeout got no out_valid expected result");
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (d !== e.data || seen != e.due) begin
            errors++;
            $display("FAIL busy_result got %h@%0d expected %h@%0d", d, seen, e.data, e.due);
         end
         $display("busy 7/2 -> %h at cycle %0d", d, seen);
      end
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL busy_extra got out_valid pulse expected none");
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      logic [19:0] d;
      bit to;
      bit extra = 1'b0;
      exp_t e;
      issue(1'b1, 1023, 7, 20'h0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 20'h0) begin
         errors++;
         $display("FAIL midreset_out got valid=%b data=%h expected valid=0 data=00000", out_valid, out_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 160; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL midreset_pulse got out_valid expected none");
      end
      issue(1'b0, 7, 2, 20'h00E00, 1'b1);
      wait_out(seen, d, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL midreset_timeout got no out_valid expected result");
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (d !== e.data || seen != e.due) begin
            errors++;
            $display("FAIL midreset_next got %h@%0d expected %h@%0d", d, seen, e.data, e.due);
         end
         $display("after reset 7/2 -> %h at cycle %0d", d, seen);
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      logic [19:0] d;
      bit to;
      exp_t e;
      issue(1'b0, 1023, 7, 20'h24892, 1'b1);
      for (int i = 0; i < 3; i++) begin
         wait_out(seen, d, to);
         if (i == 0)      issue(1'b1, 100, 2, 20'h02800, 1'b1);
         else if (i == 1) issue(1'b0, 0, 3, 20'h00000, 1'b1);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL b2b_timeout op %0d got no out_valid expected result", i);
            if (sb.size() > 0) void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (d !== e.data || seen != e.due) begin
               errors++;
               $display("FAIL b2b_result op %0d got %h@%0d expected %h@%0d", i, d, seen, e.data, e.due);
            end
            $display("b2b op %0d -> %h at cycle %0d", i, d, seen);
         end
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_root();
      test_busy_ignore();
      test_reset_mid_op();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_root_engine.md
DIV_ROOT_ENGINE -- requirements
Module: div_root_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, clock and reset ports listed first.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  single-cycle request strobe; operands sampled on the same edge.
REQ-005 in_mode  input  1  0 = divide (in_data_1 / in_data_2), 1 = n-th root (in_data_1^(1/in_data_2)).
REQ-006 in_data_1  input  10  unsigned integer operand x.
REQ-007 in_data_2  input  3  unsigned divisor or root order k.
REQ-008 out_valid  output  1  single-cycle result strobe.
REQ-009 out_data  output  20  unsigned 10.10 fixed-point result (bit 19 = 512, bit 0 = 2^-10).

Function
REQ-010 States SHALL be IDLE, DIV, ROOT_MUL, ROOT_CMP, DONE; IDLE->DIV (mode 0) or ->ROOT_MUL/ROOT_CMP (mode 1) on in_valid; DONE->IDLE unconditionally.
REQ-011 in_valid SHALL be accepted only in IDLE; strobes in any other state are ignored without effect.
REQ-012 Divide mode SHALL perform restoring division of {x,10'b0} by k, one quotient bit per cycle, MSB first, 20 DIV cycles.
REQ-013 Divide result SHALL be floor(x*1024/k), exact for all x, k in 1..7.
REQ-014 Root mode SHALL determine result bits 19..0 MSB first: trial = r | bit; compute p = trial^k by k-1 chained multiplies, one per ROOT_MUL cycle; ROOT_CMP keeps bit if p <= {x,10'b0}.
REQ-015 Each multiply SHALL be 20x20 -> 40 bits, take bits [29:10]; any set bit in [39:30] SHALL mark p as saturated (treated as greater than x).
REQ-016 k = 1 in root mode SHALL skip ROOT_MUL (p = trial); result = {x,10'b0}.
REQ-017 Latency from capture edge to out_valid high SHALL be 21 cycles in divide mode and 20*k+1 cycles in root mode (max 141).
REQ-018 out_valid SHALL be high for exactly one cycle (DONE); out_data SHALL hold the result during that cycle and 20'h0 at all other times.
REQ-019 k = 0: divide mode SHALL return 20'hFFFFF, root mode SHALL return 20'h0, both with 21-cycle latency.
REQ-020 x = 0 SHALL return 20'h0 in both modes at normal latency.
REQ-021 A new request SHALL be accepted in the cycle after DONE (back-to-back).

Reset
REQ-022 Asserting rst_n low SHALL immediately force state IDLE, out_valid 0, out_data 0, all datapath registers 0.
REQ-023 Reset mid-operation SHALL abort the operation with no out_valid pulse; first request after release is processed normally.

Configuration
REQ-024 Macro DIV_ROOT_ROUND_EN, when defined, SHALL add one guard quotient bit in divide mode and round half up (latency 22), saturating at 20'hFFFFF.
REQ-025 Without DIV_ROOT_ROUND_EN, divide mode SHALL truncate (REQ-013, latency 21); root mode SHALL be identical in both builds.

Structure
REQ-026 Shared package div_root_pkg SHALL hold the state enum, mode constants (MODE_DIV, MODE_ROOT), and width constants (IN1_W=10, IN2_W=3, OUT_W=20, FRAC_W=10).
REQ-027 One sub-module fx_mul SHALL implement the combinational 20x20 10.10 multiply with saturation flag per REQ-015.

Verification
REQ-028 Divide 7/2 -> out_data 20'h00E00 exactly 21 cycles after capture, out_valid one cycle wide.
REQ-029 Divide 1023/7 -> 20'h24892; 2/3 -> 20'h002AA (20'h002AB with DIV_ROOT_ROUND_EN, latency 22).
REQ-030 Root 100, k=2 -> 20'h02800 at latency 41; 8, k=3 -> 20'h00800 at latency 61; 1023, k=1 -> 20'hFFC00 at latency 21.
REQ-031 Root 1023, k=7 -> result r with r^7 (chained-truncated) <= 1023 < (r+2^-10)^7, latency 141, no saturation errors.
REQ-032 in_valid pulsed during busy -> ignored, original result unchanged; k=0 divide -> 20'hFFFFF.
REQ-033 rst_n low at cycle 10 of a root op -> no out_valid, outputs 0; next request 7/2 -> 20'h00E00 normally.
